// File: rtl/lsu_mem_stage_if.sv
// Data-memory request bus between the load/store unit (master) and data memory (slave).
// One request is held at a time; the slave completes it with a single-cycle mem_ack.
interface lsu_mem_stage_if #(parameter int D_WIDTH = 32);
  logic               mem_req;
  logic               mem_we;
  logic [D_WIDTH-1:0] mem_addr;
  logic [3:0]         mem_be;
  logic [D_WIDTH-1:0] mem_wdata;
  logic               mem_ack;
  logic [D_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: byte enables, store lane replication, load alignment/extension; LSU_MISALIGN_TRAP_EN traps misaligned ops.
// Latency: done 2 cycles after accept plus memory wait cycles (1 cycle for a trapped op); stall holds upstream until done.
module lsu_mem_stage #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               stall,
  output logic               done,
  output logic [D_WIDTH-1:0] rdata_o,
  output logic               err,
  lsu_mem_stage_if.master    mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, nxt;
  logic [D_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]         f3_q;
  logic               we_q;
  logic               accept;
  logic [3:0]         be;
  logic [D_WIDTH-1:0] lane_wdata, ld_val;
  logic [7:0]         rbyte;
  logic [15:0]        rhalf;

  assign accept  = (state == IDLE) && valid_i && (memread || memwrite);
  assign rdata_o = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic in_mis, mis_q;

  always_comb begin
    in_mis = 1'b0;
    case (funct3[1:0])
      2'b00:   in_mis = 1'b0;
      2'b01:   in_mis = addr[0];
      default: in_mis = |addr[1:0];
    endcase
  end

  assign err = (state == DONE) && mis_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          nxt   = in_mis ? DONE : REQ;
`else
          nxt   = REQ;
`endif
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Size decode on funct3[1:0]: 00 byte, 01 half, anything else word.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata_q;
    ld_val     = mem.mem_rdata;
    rbyte      = mem.mem_rdata[7:0];
    rhalf      = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (addr_q[1:0])
      2'b00:   rbyte = mem.mem_rdata[7:0];
      2'b01:   rbyte = mem.mem_rdata[15:8];
      2'b10:   rbyte = mem.mem_rdata[23:16];
      default: rbyte = mem.mem_rdata[31:24];
    endcase
    case (f3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
        ld_val     = f3_q[2] ? {{(D_WIDTH-8){1'b0}}, rbyte} : {{(D_WIDTH-8){rbyte[7]}}, rbyte};
      end
      2'b01: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
        ld_val     = f3_q[2] ? {{(D_WIDTH-16){1'b0}}, rhalf} : {{(D_WIDTH-16){rhalf[15]}}, rhalf};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
        ld_val     = mem.mem_rdata;
      end
    endcase
  end

  // Bus is driven only in REQ so a reset drops mem_req with the state register.
  always_comb begin
    mem.mem_req   = (state == REQ);
    mem.mem_we    = (state == REQ) && we_q;
    mem.mem_addr  = (state == REQ) ? {addr_q[D_WIDTH-1:2], 2'b00} : '0;
    mem.mem_be    = (state == REQ) ? be : 4'b0000;
    mem.mem_wdata = (state == REQ) ? lane_wdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        f3_q    <= funct3;
        we_q    <= memwrite;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q   <= in_mis;
        if (in_mis) rdata_q <= '0;
`endif
      end
      if ((state == REQ) && mem.mem_ack && !we_q) rdata_q <= ld_val;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized and directed bench for lsu_mem_stage against an arithmetic reference model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.D_WIDTH(32)) mem_bus ();

  lsu_mem_stage #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata_o(rdata_o), .err(err), .mem(mem_bus)
  );

  typedef struct {
    int          req_cycles;
    bit          stable;
    logic [31:0] maddr;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    int          done_cnt;
    int          done_lat;
    int          stall_cnt;
    logic [31:0] rd;
    logic        er;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    return (s == 2 && (a % 2) != 0) || (s == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    if (s == 1) return 4'(1 << (a % 4));
    if (s == 2) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    int s = m_size(f3);
    if (s == 1) return (wd & 32'd255) * 32'h0101_0101;
    if (s == 2) return (wd & 32'd65535) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int s = m_size(f3);
    bit sgn = (f3 < 3'd4);
    logic [31:0] v;
    if (s == 1) begin
      v = (r >> (8 * (a % 4))) & 32'd255;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (s == 2) begin
      v = (r >> (16 * ((a / 2) % 2))) & 32'd65535;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] rdat, output obs_t o);
    o = '{default: 0};
    o.stable   = 1'b1;
    o.done_lat = -1;
    @(negedge clk);
    valid_i = 1'b1; memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        // valid_i and op fields toggle randomly while busy; they must be ignored
        valid_i  = (o.done_lat < 0) ? 1'($urandom) : 1'b0;
        memread  = 1'($urandom);
        memwrite = 1'($urandom);
        addr     = $urandom;
      end
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = $urandom;
      #1;
      if (mem_bus.mem_req) begin
        if (o.req_cycles == 0) begin
          o.maddr = mem_bus.mem_addr; o.mwe = mem_bus.mem_we;
          o.mbe   = mem_bus.mem_be;   o.mwd = mem_bus.mem_wdata;
        end else if (o.maddr !== mem_bus.mem_addr || o.mwe !== mem_bus.mem_we ||
                     o.mbe !== mem_bus.mem_be || o.mwd !== mem_bus.mem_wdata) begin
          o.stable = 1'b0;
        end
        if (o.req_cycles == dly) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = rdat;
        end
        o.req_cycles++;
      end
      if (stall) o.stall_cnt++;
      if (done) begin
        o.done_cnt++;
        if (o.done_lat < 0) begin
          o.done_lat = c; o.rd = rdata_o; o.er = err;
        end
      end
      if (o.done_lat >= 0 && c >= o.done_lat + 1) break;
      @(negedge clk);
    end
    valid_i = 1'b0;
    mem_bus.mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; valid_i = 0; memread = 0; memwrite = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
    #12;
    checks++;
    if ({stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be});
    end
    checks++;
    if ({rdata_o, mem_bus.mem_addr, mem_bus.mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: rdata_o=%h mem_addr=%h mem_wdata=%h want 0", rdata_o, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store();
    obs_t o;
    logic [31:0] a;
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0, o);
    checks++; if (o.maddr !== 32'h104) begin errors++; $display("FAIL sw_addr: got %h want 00000104", o.maddr); end
    checks++; if (o.mwe !== 1'b1) begin errors++; $display("FAIL sw_we: got %b want 1", o.mwe); end
    checks++; if (o.mbe !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", o.mbe); end
    checks++; if (o.mwd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", o.mwd); end
    checks++; if (o.done_lat !== 2) begin errors++; $display("FAIL sw_done_lat: got %0d want 2", o.done_lat); end
    checks++; if (o.stall_cnt !== 2) begin errors++; $display("FAIL sw_stall_cycles: got %0d want 2", o.stall_cnt); end
    checks++; if (o.done_cnt !== 1) begin errors++; $display("FAIL sw_done_count: got %0d want 1", o.done_cnt); end

    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0, o);
    checks++; if (o.mbe !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", o.mbe); end
    checks++; if (o.mwd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.mwd); end
    checks++; if (o.maddr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", o.maddr); end

    a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b10};
    run_op(1'b1, 1'b1, 3'b001, a, 32'h1234_5678, 0, 32'h0, o);
    checks++; if (o.mbe !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", o.mbe); end
    checks++; if (o.mwd !== 32'h5678_5678) begin errors++; $display("FAIL sh_wdata: got %h want 56785678", o.mwd); end
    checks++; if (o.mwe !== 1'b1) begin errors++; $display("FAIL sh_both_is_store: got %b want 1", o.mwe); end
  endtask

  task automatic test_load();
    obs_t o;
    run_op(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 0, 32'h1280_FF00, o);
    checks++; if (o.rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h want ffffff80", o.rd); end
    checks++; if (o.mwe !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", o.mwe); end
    run_op(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 0, 32'h1280_FF00, o);
    checks++; if (o.rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", o.rd); end
    run_op(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h1280_FF00, o);
    checks++; if (o.rd !== 32'h0000_1280) begin errors++; $display("FAIL lh: got %h want 00001280", o.rd); end
    run_op(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 0, 32'h1280_FF00, o);
    checks++; if (o.rd !== 32'h0000_FF00) begin errors++; $display("FAIL lhu: got %h want 0000ff00", o.rd); end
    // store after load leaves rdata_o untouched
    run_op(1'b0, 1'b1, 3'b010, 32'h500, 32'hCAFE_F00D, 0, 32'h0, o);
    checks++; if (o.rd !== 32'h0000_FF00) begin errors++; $display("FAIL store_keeps_rdata: got %h want 0000ff00", o.rd); end
  endtask

  task automatic test_wait();
    obs_t o;
    logic [31:0] r = $urandom;
    logic [31:0] a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    run_op(1'b1, 1'b0, 3'b010, a, 32'h0, 3, r, o);
    checks++; if (o.req_cycles !== 4) begin errors++; $display("FAIL wait_req_cycles: got %0d want 4", o.req_cycles); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL wait_bus_stable: got %b want 1", o.stable); end
    checks++; if (o.stall_cnt !== 5) begin errors++; $display("FAIL wait_stall_cycles: got %0d want 5", o.stall_cnt); end
    checks++; if (o.done_cnt !== 1) begin errors++; $display("FAIL wait_done_count: got %0d want 1", o.done_cnt); end
    checks++; if (o.done_lat !== 5) begin errors++; $display("FAIL wait_done_lat: got %0d want 5", o.done_lat); end
    checks++; if (o.rd !== r) begin errors++; $display("FAIL wait_rdata: got %h want %h", o.rd, r); end
    checks++; if (o.maddr !== a) begin errors++; $display("FAIL wait_addr: got %h want %h", o.maddr, a); end
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    logic [31:0] r = $urandom;
    @(negedge clk);
    valid_i = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", mem_bus.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop: got %b want 0", mem_bus.mem_req); end
    checks++; if ({stall, done, rdata_o} !== 34'd0) begin errors++; $display("FAIL rst_outputs: stall=%b done=%b rdata_o=%h want 0", stall, done, rdata_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_bus.mem_ack   = (c == 0);
      mem_bus.mem_rdata = $urandom;
      #1;
      checks++;
      if ({done, stall, mem_bus.mem_req} !== 3'b000) begin
        errors++; $display("FAIL rst_late_ack c%0d: done=%b stall=%b mem_req=%b want 000", c, done, stall, mem_bus.mem_req);
      end
    end
    mem_bus.mem_ack = 1'b0;
    run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 1, r, o);
    checks++; if (o.done_lat !== 3 || o.rd !== r) begin errors++; $display("FAIL rst_next_op: lat=%0d rdata=%h want 3 %h", o.done_lat, o.rd, r); end
  endtask

  task automatic test_misalign();
    obs_t o;
    logic [31:0] r = $urandom;
    run_op(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 0, r, o);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL mis_no_req: got %0d want 0", o.req_cycles); end
    checks++; if (o.done_lat !== 1) begin errors++; $display("FAIL mis_done_lat: got %0d want 1", o.done_lat); end
    checks++; if (o.er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", o.er); end
    checks++; if (o.rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", o.rd); end
`else
    checks++; if (o.maddr !== 32'h300) begin errors++; $display("FAIL mis_addr: got %h want 00000300", o.maddr); end
    checks++; if (o.mbe !== 4'b1111) begin errors++; $display("FAIL mis_be: got %b want 1111", o.mbe); end
    checks++; if (o.er !== 1'b0) begin errors++; $display("FAIL mis_err: got %b want 0", o.er); end
    checks++; if (o.rd !== r) begin errors++; $display("FAIL mis_rdata: got %h want %h", o.rd, r); end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] hold = 32'h0;
    bit known = 1'b0;
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] r   = $urandom;
      int          dly = $urandom_range(0, 3);
      int          op  = $urandom_range(0, 2);
      bit          st  = (op != 0);
      bit          tr;
      run_op(op != 1, st, f3, a, wd, dly, r, o);
      tr = TRAP && m_mis(f3, a);
      if (tr) begin
        checks++;
        if (o.req_cycles !== 0 || o.done_lat !== 1 || o.er !== 1'b1 || o.rd !== 32'h0) begin
          errors++; $display("FAIL rnd%0d_trap: req=%0d lat=%0d err=%b rdata=%h want 0 1 1 0", n, o.req_cycles, o.done_lat, o.er, o.rd);
        end
        known = 1'b0;
      end else begin
        checks++;
        if (o.req_cycles !== dly + 1 || o.done_lat !== dly + 2 || o.done_cnt !== 1 || o.er !== 1'b0 || o.stable !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_timing: req=%0d lat=%0d dones=%0d err=%b stable=%b dly=%0d", n, o.req_cycles, o.done_lat, o.done_cnt, o.er, o.stable, dly);
        end
        checks++;
        if (o.maddr !== (a & ~32'd3) || o.mbe !== m_be(f3, a) || o.mwe !== st) begin
          errors++; $display("FAIL rnd%0d_bus: addr=%h be=%b we=%b want %h %b %b", n, o.maddr, o.mbe, o.mwe, a & ~32'd3, m_be(f3, a), st);
        end
        if (st) begin
          checks++;
          if (o.mwd !== m_wd(f3, wd)) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o.mwd, m_wd(f3, wd)); end
          if (known) begin
            checks++;
            if (o.rd !== hold) begin errors++; $display("FAIL rnd%0d_hold: got %h want %h", n, o.rd, hold); end
          end
        end else begin
          hold = m_ld(f3, a, r);
          known = 1'b1;
          checks++;
          if (o.rd !== hold) begin errors++; $display("FAIL rnd%0d_load f3=%b a=%h: got %h want %h", n, f3, a, o.rd, hold); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait();
    test_reset_mid_req();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
